// File: rtl/log10_stream.sv
// Streaming fixed-point log10 of an unsigned fraction: normalise by powers of two, then CORDIC refine.
// Latency ceil((clog2(DIN_W)+NUM_ITER)/REG_EVERY) cycles, one sample per cycle when not stalled.
// Backpressure: the whole pipe freezes while the output is valid and not accepted (in_ready = enable).
module log10_stream #(
  parameter int DIN_W     = 24,
  parameter int FRAC_W    = 12,
  parameter int DOUT_W    = 17,
  parameter int NUM_ITER  = 8,
  parameter int REG_EVERY = 4,
  parameter int TAG_W     = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [DIN_W-1:0]  i_in_data,
  input  logic [TAG_W-1:0]  i_in_tag,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [DOUT_W-1:0] o_out_data,
  output logic [TAG_W-1:0]  o_out_tag,
  output logic              o_out_zero
);

  localparam int NORM_N = $clog2(DIN_W);
  localparam int S      = NORM_N + NUM_ITER;
  localparam logic signed [DOUT_W-1:0] Y_MIN = {1'b1, {(DOUT_W-1){1'b0}}};

  // floor(log10(1 + 2^-k) * 2^FRAC_W); k = 0 yields the log10(2) step used by normalisation.
  function automatic int calc_const(input int k);
    real v;
    v = $log10(1.0 + 1.0 / (2.0 ** k)) * (2.0 ** FRAC_W);
    return $rtoi(v);
  endfunction

  localparam int L2 = calc_const(0);

  // Index i carries the values leaving stage i (after its register, if it has one); index 0 is the input.
  logic [DIN_W-1:0]         w_xs [0:S];
  logic signed [DOUT_W-1:0] w_ys [0:S];
  logic                     w_zs [0:S];
  logic                     w_vs [0:S];
  logic [TAG_W-1:0]         w_ts [0:S];
  logic                     w_en;
  logic                     w_unused;

  assign w_en       = !o_out_valid || i_out_ready;
  assign o_in_ready = w_en;

  assign w_xs[0] = i_in_data;
  assign w_ys[0] = '0;
  assign w_zs[0] = (i_in_data == '0);
  assign w_vs[0] = i_in_valid;
  assign w_ts[0] = i_in_tag;

  for (genvar gi = 1; gi <= S; gi++) begin : g_stage
    logic [DIN_W-1:0]         w_xn;
    logic signed [DOUT_W-1:0] w_yn;

    if (gi <= NORM_N) begin : g_norm
      localparam int SH = 1 << (NORM_N - gi);
      localparam logic signed [DOUT_W-1:0] DY = DOUT_W'(SH * L2);
      logic w_hit;
      assign w_hit = (w_xs[gi-1][DIN_W-1 -: SH] == '0);
      assign w_xn  = w_hit ? (w_xs[gi-1] << SH) : w_xs[gi-1];
      assign w_yn  = w_hit ? (w_ys[gi-1] - DY) : w_ys[gi-1];
    end else begin : g_cordic
      localparam int K = gi - NORM_N;
      localparam logic signed [DOUT_W-1:0] CK = DOUT_W'(calc_const(K));
      logic [DIN_W:0] w_t;
      // Multiply by (1 + 2^-k) only while the product stays below 1.0.
      assign w_t  = {1'b0, w_xs[gi-1]} + {1'b0, (w_xs[gi-1] >> K)};
      assign w_xn = w_t[DIN_W] ? w_xs[gi-1] : w_t[DIN_W-1:0];
      assign w_yn = w_t[DIN_W] ? w_ys[gi-1] : (w_ys[gi-1] - CK);
    end

    if (((gi % REG_EVERY) == 0) || (gi == S)) begin : g_reg
      logic [DIN_W-1:0]         r_x;
      logic signed [DOUT_W-1:0] r_y;
      logic                     r_z;
      logic                     r_v;
      logic [TAG_W-1:0]         r_t;

      // Stage register: advances only on the global enable; the last one substitutes the zero-input code.
      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          r_x <= '0;
          r_y <= '0;
          r_z <= 1'b0;
          r_v <= 1'b0;
          r_t <= '0;
        end else if (w_en) begin
          r_x <= w_xn;
          r_y <= ((gi == S) && w_zs[gi-1]) ? Y_MIN : w_yn;
          r_z <= w_zs[gi-1];
          r_v <= w_vs[gi-1];
          r_t <= w_ts[gi-1];
        end
      end

      assign w_xs[gi] = r_x;
      assign w_ys[gi] = r_y;
      assign w_zs[gi] = r_z;
      assign w_vs[gi] = r_v;
      assign w_ts[gi] = r_t;
    end else begin : g_pass
      assign w_xs[gi] = w_xn;
      assign w_ys[gi] = w_yn;
      assign w_zs[gi] = w_zs[gi-1];
      assign w_vs[gi] = w_vs[gi-1];
      assign w_ts[gi] = w_ts[gi-1];
    end
  end

  // The residual mantissa after the last stage carries no information for the result.
  assign w_unused = ^w_xs[S];

  assign o_out_valid = w_vs[S];
  assign o_out_data  = w_ys[S];
  assign o_out_tag   = w_ts[S];
  assign o_out_zero  = w_zs[S];

endmodule

// File: tb/tb_log10_stream.sv
// Bench for log10_stream: directed vectors on two configurations, streaming, stall and reset cases.
// Outputs are sampled 1 time unit after the rising edge; inputs are driven at the same point.
// A small integer model of the default configuration checks the random streams.
module tb_log10_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default configuration instance
  logic        rst1, iv1, ir1, ov1, ordy1, oz1;
  logic [23:0] id1;
  logic [1:0]  it1, ot1;
  logic [16:0] od1;

  // DIN_W=16, FRAC_W=10, NUM_ITER=10, REG_EVERY=1 instance
  logic        rst2, iv2, ir2, ov2, ordy2, oz2;
  logic [15:0] id2;
  logic [1:0]  it2, ot2;
  logic [16:0] od2;

  log10_stream dut (
    .i_clk(clk), .i_rst(rst1), .i_in_valid(iv1), .o_in_ready(ir1), .i_in_data(id1), .i_in_tag(it1),
    .o_out_valid(ov1), .i_out_ready(ordy1), .o_out_data(od1), .o_out_tag(ot1), .o_out_zero(oz1)
  );

  log10_stream #(.DIN_W(16), .FRAC_W(10), .DOUT_W(17), .NUM_ITER(10), .REG_EVERY(1), .TAG_W(2)) dut2 (
    .i_clk(clk), .i_rst(rst2), .i_in_valid(iv2), .o_in_ready(ir2), .i_in_data(id2), .i_in_tag(it2),
    .o_out_valid(ov2), .i_out_ready(ordy2), .o_out_data(od2), .o_out_tag(ot2), .o_out_zero(oz2)
  );

  typedef struct {
    logic [23:0] din;
    logic [1:0]  tag;
    int          expv;
    logic        zero;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input int act, input int expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic out_valid(input int which);
    return (which == 0) ? ov1 : ov2;
  endfunction

  function automatic int out_data(input int which);
    return (which == 0) ? int'($signed(od1)) : int'($signed(od2));
  endfunction

  // Integer model of the default configuration (24-bit in, 12 fractional bits out, 8 iterations).
  function automatic int model24(input logic [23:0] d);
    int          ck [8] = '{721, 396, 209, 107, 54, 27, 13, 6};
    int          sh [5] = '{16, 8, 4, 2, 1};
    logic [23:0] x;
    logic [24:0] t;
    int          y;
    if (d == 24'd0) return -65536;
    x = d;
    y = 0;
    for (int j = 0; j < 5; j++) begin
      if ((x >> (24 - sh[j])) == 24'd0) begin
        x = x << sh[j];
        y = y - sh[j] * 1233;
      end
    end
    for (int k = 1; k <= 8; k++) begin
      t = {1'b0, x} + {1'b0, (x >> k)};
      if (!t[24]) begin
        x = t[23:0];
        y = y - ck[k-1];
      end
    end
    return y;
  endfunction

  // Send one sample, measure cycles until it appears, compare, then confirm the pipe is empty.
  task automatic run_vec(input int which, input vec_t v, input int lat, input string name);
    int n;
    if (which == 0) begin iv1 = 1'b1; id1 = v.din; it1 = v.tag; end
    else begin iv2 = 1'b1; id2 = v.din[15:0]; it2 = v.tag; end
    tick;
    iv1 = 1'b0;
    iv2 = 1'b0;
    n = 1;
    while (!out_valid(which) && n < 64) begin
      tick;
      n++;
    end
    check({name, " latency"}, n, lat);
    check({name, " data"}, out_data(which), v.expv);
    check({name, " tag"}, int'((which == 0) ? ot1 : ot2), int'(v.tag));
    check({name, " zero"}, int'((which == 0) ? oz1 : oz2), int'(v.zero));
    tick;
    check({name, " drained"}, int'(out_valid(which)), 0);
  endtask

  vec_t        vt1 [6];
  vec_t        vt2 [4];
  logic [23:0] samp [16];
  int          sexp [16];
  int          qexp [$];
  int          qtag [$];
  int          acc, got, cyc, first, last, stray;
  logic        a;

  initial begin
    vt1[0] = '{24'h800000, 2'd1, -1230,  1'b0};
    vt1[1] = '{24'h000001, 2'd2, -29589, 1'b0};
    vt1[2] = '{24'h400000, 2'd3, -2463,  1'b0};
    vt1[3] = '{24'hFFFFFF, 2'd0, 0,      1'b0};
    vt1[4] = '{24'h000000, 2'd2, -65536, 1'b1};
    vt1[5] = '{24'hC00000, 2'd1, -509,   1'b0};
    vt2[0] = '{24'h008000, 2'd1, -306,   1'b0};
    vt2[1] = '{24'h000001, 2'd2, -4926,  1'b0};
    vt2[2] = '{24'h00FFFF, 2'd3, 0,      1'b0};
    vt2[3] = '{24'h000000, 2'd0, -65536, 1'b1};

    rst1 = 1'b1; iv1 = 1'b0; id1 = '0; it1 = '0; ordy1 = 1'b1;
    rst2 = 1'b1; iv2 = 1'b0; id2 = '0; it2 = '0; ordy2 = 1'b1;
    tick;
    tick;
    rst1 = 1'b0;
    rst2 = 1'b0;

    // Reset state
    check("reset out_valid", int'(ov1), 0);
    check("reset out_data", int'(od1), 0);
    check("reset out_tag", int'(ot1), 0);
    check("reset out_zero", int'(oz1), 0);
    check("reset in_ready", int'(ir1), 1);
    check("reset2 out_valid", int'(ov2), 0);

    // Directed vectors, both configurations
    for (int i = 0; i < 6; i++) run_vec(0, vt1[i], 4, $sformatf("vec%0d", i));
    for (int i = 0; i < 4; i++) run_vec(1, vt2[i], 14, $sformatf("cfg2 vec%0d", i));

    // Back-to-back stream of 16 samples with out_ready high
    for (int i = 0; i < 16; i++) begin
      samp[i] = 24'($urandom() >> $urandom_range(0, 23));
      sexp[i] = model24(samp[i]);
    end
    got = 0; cyc = 0; first = -1; last = -1;
    fork
      begin
        for (int i = 0; i < 16; i++) begin
          iv1 = 1'b1; id1 = samp[i]; it1 = 2'(i);
          tick;
        end
        iv1 = 1'b0;
      end
      begin
        while (got < 16 && cyc < 200) begin
          tick;
          cyc++;
          if (ov1) begin
            check($sformatf("stream data %0d", got), int'($signed(od1)), sexp[got]);
            check($sformatf("stream tag %0d", got), int'(ot1), got % 4);
            if (first < 0) first = cyc;
            last = cyc;
            got++;
          end
        end
      end
    join
    check("stream count", got, 16);
    check("stream first latency", first, 4);
    check("stream spacing", last - first, 15);
    tick;
    check("stream drained", int'(ov1), 0);

    // Fill the pipe with out_ready low, hold, then drain
    ordy1 = 1'b0;
    acc = 0;
    for (int i = 0; i < 8; i++) begin
      iv1 = 1'b1; id1 = 24'h010000 + 24'(i * 24'h051234); it1 = 2'(i);
      a = ir1;
      tick;
      if (a) begin
        qexp.push_back(model24(id1));
        qtag.push_back(i % 4);
        acc++;
      end
    end
    iv1 = 1'b0;
    check("stall in_ready", int'(ir1), 0);
    check("stall accepted", acc, 4);
    for (int i = 0; i < 5; i++) begin
      tick;
      check("stall hold valid", int'(ov1), 1);
      check("stall hold data", int'($signed(od1)), qexp[0]);
      check("stall hold tag", int'(ot1), qtag[0]);
    end
    ordy1 = 1'b1;
    got = 0;
    for (int c = 0; c < 40; c++) begin
      if (ov1) begin
        if (got < acc) begin
          check($sformatf("drain data %0d", got), int'($signed(od1)), qexp[got]);
          check($sformatf("drain tag %0d", got), int'(ot1), qtag[got]);
        end
        got++;
      end
      tick;
    end
    check("drain count", got, acc);

    // Reset with three samples in flight
    for (int i = 0; i < 3; i++) begin
      iv1 = 1'b1; id1 = 24'h123456 + 24'(i); it1 = 2'(i);
      tick;
    end
    iv1 = 1'b0;
    rst1 = 1'b1;
    tick;
    rst1 = 1'b0;
    check("midreset out_valid", int'(ov1), 0);
    check("midreset in_ready", int'(ir1), 1);
    check("midreset out_data", int'(od1), 0);
    stray = 0;
    for (int i = 0; i < 8; i++) begin
      tick;
      if (ov1) stray++;
    end
    check("midreset stray outputs", stray, 0);
    run_vec(0, '{24'h800000, 2'd3, -1230, 1'b0}, 4, "post-reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/log10_stream.md
Name: log10_stream

Overview:
- Parametrised streaming fixed-point log10 unit. Successor to the fixed 24-bit CORDIC log10 used in the audio meter path.
- Adds the following over that unit:
  - generic input width, fractional precision and iteration count;
  - configurable pipeline register spacing;
  - valid/ready backpressure;
  - a channel tag carried alongside each sample (e.g. L/R meter channels sharing one instance);
  - explicit zero-input detection.
- Sits between the per-channel peak/RMS detector and the dB-to-segment mapper.

Parameters:
- DIN_W, 24: input width; unsigned fraction 0.xxx (DIN_W bits), range [0,1).
- FRAC_W, 12: output fractional bits.
- DOUT_W, 17: output width, signed two's complement. Must satisfy 2^(DOUT_W-1) > DIN_W*floor(log10(2)*2^FRAC_W) + 2^FRAC_W.
- NUM_ITER, 8: CORDIC iterations, k = 1..NUM_ITER; 1 ≤ NUM_ITER < DIN_W.
- REG_EVERY, 4: insert a pipeline register after every REG_EVERY combinational stages. 1 ≤ REG_EVERY ≤ total stage count.
- TAG_W, 2: width of the sideband tag.

Ports:
- clk, in, 1: clock.
- rst, in, 1: synchronous reset, active-high.
- in_valid, in, 1: input sample valid.
- in_ready, out, 1: block can accept a sample this cycle.
- in_data, in, DIN_W: input fraction.
- in_tag, in, TAG_W: channel tag, travels with the sample.
- out_valid, out, 1: output valid.
- out_ready, in, 1: downstream accepts the output.
- out_data, out, DOUT_W: log10(in_data), signed, FRAC_W fractional bits.
- out_tag, out, TAG_W: tag of the sample on out_data.
- out_zero, out, 1: the sample had in_data == 0.

Behaviour:
- Reset: synchronous. Clears every stage-valid bit. Outputs after reset: out_valid=0, out_data=0, out_tag=0, out_zero=0. Data registers also clear to 0. Reset mid-stream discards all in-flight samples with no output for them. in_ready=1 in the cycle after reset deasserts.

Stages (total S = NORM_N + NUM_ITER):
- Normalisation stages: NORM_N = $clog2(DIN_W) stages, shift s = 2^j for j = NORM_N-1 down to 0.
  - If the top s bits of x are zero: x <<= s, y -= s*L2, where L2 = floor(log10(2)*2^FRAC_W).
  - Otherwise x and y pass through unchanged.
  - y starts at 0.
- CORDIC stages, k = 1..NUM_ITER:
  - t = x + (x >> k), computed DIN_W+1 bits wide.
  - If t[DIN_W] == 0: x = t[DIN_W-1:0], y -= Ck, where Ck = floor(log10(1+2^-k)*2^FRAC_W).
  - Otherwise x and y are unchanged.
- All constants are computed at elaboration (real constant function). Defaults give:
  - L2 = 1233;
  - Ck = 721, 396, 209, 107, 54, 27, 13, 6.
- The result is bit-exact to this algorithm. The golden model implements the same integer steps.

Pipelining and latency:
- A register follows stage index i (1-based) whenever i mod REG_EVERY == 0.
- The final stage is always registered.
- LAT = ceil(S/REG_EVERY) cycles. Default LAT = ceil(13/4) = 4.
- tag, zero flag and valid travel in lockstep with x/y.

Handshake:
- Global enable en = !out_valid || out_ready. in_ready = en.
- A sample is accepted when in_valid && in_ready.
- When en=0, all pipeline registers hold, and out_data, out_tag and out_zero hold stable.
- Bubbles (stage-valid=0) do not compress. The pipe advances only on en.
- Throughput is 1 sample/cycle with no stall.
- Output transfer occurs when out_valid && out_ready.

Zero input:
- in_data == 0 sets the zero flag at stage entry.
- Output: out_zero=1, out_data = most negative value (-2^(DOUT_W-1)).
- Non-zero inputs always produce out_zero=0.

Full scale: in_data all-ones yields 0.

Test Plan:
- Defaults, in_data=0x800000, tag=1 → 4 cycles later out_valid=1, out_data=-1230 (0x1FB32), out_tag=1, out_zero=0.
- in_data=0x000001 → out_data=-29589. in_data=0x400000 → -2463. in_data=0xFFFFFF → 0.
- in_data=0 → out_data=0x10000 (-65536), out_zero=1.
- Back-to-back 16 random samples with alternating tags and out_ready=1 → one output per cycle, order and tags preserved, all values matching the golden model.
- out_ready held 0 with the pipe full → in_ready=0 and outputs stable. Release → samples drain in order, none lost or duplicated.
- Assert rst while 3 samples are in flight → out_valid=0 the next cycle. No stale outputs appear. A fresh sample after reset gives the correct result in 4 cycles.
- Rerun scenario 1 with DIN_W=16, FRAC_W=10, NUM_ITER=10, REG_EVERY=1 → LAT=14, result matching the golden model.
